// File: rtl/latch_array.sv
// latch_array: CHANNELS lanes of WIDTH-bit clocked "transparent-low" latches.
// Each lane's active-low gate passes through a stability filter before it
// takes effect; a four-phase snapshot handshake copies every lane's q on a
// single edge so downstream logic sees a coherent set of values.
//
// Optional feature: define LATCH_ARRAY_PARITY_EN to register per-lane even
// parity alongside q. Without it, par is tied to zero and no parity logic
// is built.
//
// FILTER must lie in 1..15 so that FILTER-1 fits the 4-bit stability counter.

module latch_array #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int FILTER   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          gate_n,
  input  logic [CHANNELS*WIDTH-1:0]    d,
  output logic [CHANNELS*WIDTH-1:0]    q,
  output logic [CHANNELS-1:0]          open,
  input  logic                         snap_req,
  output logic                         snap_ack,
  output logic [CHANNELS*WIDTH-1:0]    snap_q,
  output logic [CHANNELS-1:0]          par
);

  localparam logic [3:0] FILTER_M1 = 4'(FILTER - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } snap_state_e;

  // Filtered gates (1 = closed) and their stability counters.
  logic [CHANNELS-1:0]         gf_q, gf_d;
  logic [CHANNELS-1:0][3:0]    cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0]   q_q, q_d;

  // Snapshot handshake state and its registered outputs.
  snap_state_e                 state_q;
  logic                        snap_ack_q;
  logic [CHANNELS*WIDTH-1:0]   snap_data_q;

  // Gate filter and lane data: next-state for every lane.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so a
    // path that skips an assignment holds the old value instead of a latch.
    gf_d  = gf_q;
    cnt_d = cnt_q;
    q_d   = q_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gate_n[i] != gf_q[i]) begin
        // Raw gate disagrees with the filtered one; it must hold steady for
        // FILTER consecutive edges before it is accepted.
        if (cnt_q[i] == FILTER_M1) begin
          gf_d[i]  = gate_n[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end else begin
        // Any bounce back to the filtered value restarts the count.
        cnt_d[i] = '0;
      end
      // Uses the pre-edge filtered gate, so the closing edge still loads.
      if (!gf_q[i]) begin
        q_d[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
      end
    end
  end

  // Lane registers: filtered gates, counters and latched data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gf_q  <= '1;
      cnt_q <= '0;
      q_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      gf_q  <= gf_d;
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  // Snapshot FSM: capture all lanes on IDLE->ACK, release when req drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      snap_ack_q  <= 1'b0;
      snap_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (snap_req) begin
            state_q     <= ACK;
            snap_ack_q  <= 1'b1;
            snap_data_q <= q_q;
          end
        end
        ACK: begin
          if (!snap_req) begin
            state_q    <= IDLE;
            snap_ack_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          snap_ack_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef LATCH_ARRAY_PARITY_EN
  logic [CHANNELS-1:0] par_q, par_d;

  // Parity tracks q: same load condition, computed from the incoming data.
  always_comb begin
    par_d = par_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!gf_q[i]) begin
        par_d[i] = ^d[i*WIDTH +: WIDTH];
      end
    end
  end

  // Parity register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par = par_q;
`else
  assign par = '0;
`endif

  assign q        = q_q;
  assign open     = ~gf_q;
  assign snap_ack = snap_ack_q;
  assign snap_q   = snap_data_q;

endmodule

// File: doc/latch_array.md
# latch_array

Parametrised, clocked multi-channel successor to the single-bit transparent-low latch. Each of `CHANNELS` lanes holds a `WIDTH`-bit value. A lane is transparent (it samples `d` every clock) while its active-low gate is open, and it holds its value while the gate is closed. Each gate is debounced by a stability filter. A four-phase snapshot handshake captures all lanes atomically. The block sits between asynchronous-ish control sources and downstream logic that needs glitch-free, coherent latched data.

## Interface
Parameters:
- `WIDTH`, 8: bits per channel (≥1).
- `CHANNELS`, 4: number of independent lanes (≥1).
- `FILTER`, 2: cycles a gate change must remain stable before it takes effect. Legal range is 1..15.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `gate_n`  input  CHANNELS  raw per-lane gate, 0 = transparent.
- `d`  input  CHANNELS*WIDTH  lane data; lane i occupies bits [i*WIDTH +: WIDTH].
- `q`  output  CHANNELS*WIDTH  latched lane data.
- `open`  output  CHANNELS  filtered gate state, 1 = lane transparent.
- `snap_req`  input  1  snapshot request (level, four-phase).
- `snap_ack`  output  1  snapshot acknowledge.
- `snap_q`  output  CHANNELS*WIDTH  atomic copy of `q` captured at acknowledge.
- `par`  output  CHANNELS  per-lane even parity of `q` (see Configuration).

## Operation
- **Per-lane filter.** Each lane has a filtered gate `gf[i]` (1 = closed) and a counter `cnt[i]` of 4 bits.
  - If `gate_n[i] != gf[i]`: when `cnt[i] == FILTER-1`, load `gf[i] <= gate_n[i]` and `cnt[i] <= 0`; otherwise `cnt[i] <= cnt[i]+1`.
  - If `gate_n[i] == gf[i]`: `cnt[i] <= 0`. Any bounce therefore restarts the count.
  - `open[i] = ~gf[i]`, driven straight from the register.
- **Data.** On each edge, if `gf[i]==0` (pre-edge value), `q[i] <= d[i]`; otherwise `q[i]` holds. Lanes are fully independent.
- **Snapshot FSM.** States are IDLE and ACK.
  - IDLE: when `snap_req==1`, `snap_q <= q` (pre-edge `q`, all lanes on the same edge) and go to ACK.
  - ACK: stay while `snap_req==1`; go to IDLE when `snap_req==0`.
  - `snap_ack` is 1 exactly in ACK and is registered.
  - `snap_q` changes only on the IDLE→ACK transition.
  - Lane updates continue during ACK and do not affect `snap_q`.
- **Reset values** (all asynchronous on `rst_n` low):
  - `q`=0, `snap_q`=0, `gf`=all 1 (closed), `open`=0, `cnt`=0, `snap_ack`=0, FSM=IDLE, `par`=0.
- **Reset mid-handshake:** `snap_ack` drops immediately. After reset is released, a requester still holding `snap_req` high receives a fresh capture on the first edge.
- **Reset mid-filter:** the partial count is discarded.

## Timing
- **Gate latency.** With a `gate_n` edge stable from cycle t, `gf`/`open` change at the FILTER-th rising edge after t. The first edge that loads `d` into `q` is the one after that. Open-to-first-load latency is FILTER+1 edges.
- **Transparent data path.** `d` to `q` is 1 cycle.
- **Close timing.** On the edge where `gf` goes to 1, `q` still loads (its pre-edge `gf` was 0). `q` freezes from the following edge.
- **Snapshot.** Request to ack is 1 edge. Ack deassertion is 1 edge after `snap_req` falls.
- **Minimum handshake.** The minimum full four-phase cycle is 2 edges.
- **Simultaneous events.** A lane opening/closing on the same edge as a capture: `snap_q` takes the pre-edge `q`.

## Configuration
- `LATCH_ARRAY_PARITY_EN` defined:
  - `par[i]` is a register updated on the same edge and under the same condition as `q[i]`.
  - Its value is the XOR of the new `q[i]` bits.
  - `par` is reset to 0.
- `LATCH_ARRAY_PARITY_EN` undefined:
  - `par` is tied to 0.
  - No parity logic is instantiated.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4, FILTER=2 unless noted.

1. **Reset.** Drive `rst_n`=0 with arbitrary inputs → `q`=0, `snap_q`=0, `open`=0, `snap_ack`=0. Assert `rst_n` low asynchronously mid-cycle → outputs clear before the next edge.
2. **Basic latch.** `gate_n[0]`=0 held, `d[0]`=8'hA5 → `open[0]`=1 after 2 edges, `q[0]`=A5 one edge later. Then `gate_n[0]`=1 and `d[0]`=8'h3C → `q[0]` remains A5. Lanes 1-3 stay 0 throughout.
3. **Glitch rejection.** `gate_n[1]` pulses low for 1 cycle → `open[1]` stays 0 and `q[1]` is unchanged. A 2-cycle low pulse opens lane 1.
4. **Snapshot coherence.** Lanes 0-3 open with a counter on `d`; raise `snap_req` → `snap_ack`=1 one edge later. `snap_q` equals `q` from the pre-edge cycle and stays constant while `q` keeps changing. Drop `snap_req` → `snap_ack`=0 one edge later.
5. **Reset mid-handshake.** Pulse `rst_n` low while `snap_ack`=1 and `snap_req` is held → `snap_ack` drops immediately. It reasserts one edge after release, with `snap_q`=0.
6. **Parity** (`LATCH_ARRAY_PARITY_EN` defined). Load `q[2]`=8'h07 → `par[2]`=1. Load 8'h03 → `par[2]`=0. With the macro undefined, `par`=0 for the same stimulus.
